// File: rtl/ws2812_frame_ctl.sv
// ws2812_frame_ctl
// Frame controller that sequences a ws2812c LED-strip driver from a
// double-buffered pixel store. Application logic writes 24-bit pixels into
// the back buffer and commits. The buffers swap only at a frame boundary,
// so the strip never shows a half-updated frame. A frame starts on a
// periodic refresh or on a commit.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-low reset
//   wr_en            write strobe into the back buffer
//   wr_addr          pixel index for the write (out-of-range writes are dropped)
//   wr_data          pixel value {red, green, blue}
//   commit           single-cycle request to display the back buffer
//   drv_address      pixel index requested by the driver
//   drv_new_address  driver pulse, one per pixel consumed
//   drv_reset        active-high driver reset / frame restart
//   red/green/blue   registered pixel data for drv_address (0 if out of range)
//   busy             high in HOLD, RUN and DONE
//   swap_pending     commit accepted, swap not yet done
//   frame_done       one-cycle pulse at the end of a completed frame
//   timeout          sticky RUN-abort flag, cleared only by reset
module ws2812_frame_ctl #(
    parameter int  NUM_LEDS       = 8,
    parameter int  REFRESH_CYCLES = 800000,
    parameter int  RESET_HOLD     = 16,
    parameter int  TIMEOUT_CYCLES = 100000,
    localparam int ADDR_W         = $clog2(NUM_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              commit,
    input  logic [ADDR_W-1:0] drv_address,
    input  logic              drv_new_address,
    output logic              drv_reset,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              busy,
    output logic              swap_pending,
    output logic              frame_done,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CNT_W = ADDR_W + 1;
    localparam int PIX_W = $clog2(NUM_LEDS + 1);

    // Address bounds are compared one bit wider than the address so that
    // power-of-two strip lengths still produce a meaningful comparison.
    localparam logic [CNT_W-1:0] LED_COUNT    = CNT_W'(NUM_LEDS);
    localparam logic [PIX_W-1:0] LAST_PIX     = PIX_W'(NUM_LEDS - 1);
    localparam logic [31:0]      REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST    = 32'(RESET_HOLD - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_swap;
    logic              w_abort;
    logic              w_hold_entry;
    logic              w_wr_ok;
    logic              w_rd_ok;

    logic              r_drv_reset;
    logic              r_front_sel;
    logic              r_swap_pending;
    logic              r_timeout;
    logic [31:0]       r_timer;      // cycles since last HOLD entry, saturating
    logic [31:0]       r_cyc_cnt;    // cycles spent in the current state
    logic [PIX_W-1:0]  r_pix_cnt;    // driver pulses seen in this frame
    logic [23:0]       r_rgb;

    logic [23:0]       r_mem [2][NUM_LEDS];

    assign w_wr_ok      = wr_en && ({1'b0, wr_addr} < LED_COUNT);
    assign w_rd_ok      = {1'b0, drv_address} < LED_COUNT;
    assign w_hold_entry = (w_next_state == S_HOLD) && (r_state != S_HOLD);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value held and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_swap       = 1'b0;
        w_abort      = 1'b0;
        busy         = (r_state != S_IDLE);
        frame_done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (r_swap_pending) begin
                    w_swap       = 1'b1;
                    w_next_state = S_HOLD;
                end else if (r_timer >= REFRESH_LAST) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cyc_cnt == HOLD_LAST) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                // Completion wins over the timeout if both land on the same cycle.
                if (drv_new_address && (r_pix_cnt == LAST_PIX)) begin
                    w_next_state = S_DONE;
                end else if (r_cyc_cnt == TIMEOUT_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_drv_reset    <= 1'b1;
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_timeout      <= 1'b0;
            r_timer        <= '0;
            r_cyc_cnt      <= '0;
            r_pix_cnt      <= '0;
            r_rgb          <= '0;
        end else begin
            r_state     <= w_next_state;
            // Registered from the next state so it tracks HOLD exactly while
            // still coming out of reset high.
            r_drv_reset <= (w_next_state == S_HOLD);

            // A commit landing on the swap cycle is merged into that swap: the
            // same-cycle write also lands in the newly displayed buffer.
            if (w_swap) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
            end else if (commit) begin
                r_swap_pending <= 1'b1;
            end

            if (w_abort) begin
                r_timeout <= 1'b1;
            end

            if (w_hold_entry) begin
                r_timer <= '0;
            end else if (r_timer < REFRESH_LAST) begin
                r_timer <= r_timer + 32'd1;
            end

            r_cyc_cnt <= (w_next_state != r_state) ? '0 : r_cyc_cnt + 32'd1;

            if (r_state == S_HOLD) begin
                r_pix_cnt <= '0;
            end else if ((r_state == S_RUN) && drv_new_address) begin
                r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end

            r_rgb <= w_rd_ok ? r_mem[r_front_sel][drv_address] : '0;
        end
    end

    // NOTE: the pixel store has no reset; frame content survives a reset and
    // a plain RAM can be inferred.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[~r_front_sel][wr_addr] <= wr_data;
        end
    end

    assign drv_reset    = r_drv_reset;
    assign swap_pending = r_swap_pending;
    assign timeout      = r_timeout;
    assign red          = r_rgb[23:16];
    assign green        = r_rgb[15:8];
    assign blue         = r_rgb[7:0];

endmodule

// File: tb/tb_ws2812_frame_ctl.sv
`timescale 1ns/1ps
module tb_ws2812_frame_ctl;

    localparam int NUM_LEDS   = 8;
    localparam int NUM_LEDS_B = 5;
    localparam int REFRESH    = 100;
    localparam int HOLD       = 16;
    localparam int TMO        = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        commit = 1'b0;
    logic [2:0]  drv_address = '0;
    logic        drv_new_address = 1'b0;

    logic        drv_reset, busy, swap_pending, frame_done, timeout;
    logic [7:0]  red, green, blue;
    logic        b_drv_reset, b_busy, b_swap_pending, b_frame_done, b_timeout;
    logic [7:0]  b_red, b_green, b_blue;

    ws2812_frame_ctl #(
        .NUM_LEDS(NUM_LEDS), .REFRESH_CYCLES(REFRESH),
        .RESET_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .drv_address(drv_address),
        .drv_new_address(drv_new_address), .drv_reset(drv_reset),
        .red(red), .green(green), .blue(blue), .busy(busy),
        .swap_pending(swap_pending), .frame_done(frame_done), .timeout(timeout)
    );

    // Five-pixel instance sharing every input: addresses 5..7 are out of range.
    ws2812_frame_ctl #(
        .NUM_LEDS(NUM_LEDS_B), .REFRESH_CYCLES(REFRESH),
        .RESET_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .drv_address(drv_address),
        .drv_new_address(drv_new_address), .drv_reset(b_drv_reset),
        .red(b_red), .green(b_green), .blue(b_blue), .busy(b_busy),
        .swap_pending(b_swap_pending), .frame_done(b_frame_done), .timeout(b_timeout)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   rise_prev = -1;
    int   rise_last = -1;
    logic dr_q      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (drv_reset === 1'b1 && dr_q === 1'b0) begin
            rise_prev = rise_last;
            rise_last = cyc;
        end
        dr_q = drv_reset;
    end

    typedef struct {
        logic [2:0] addr;
        logic       pulse;
        logic       exp_done;
    } frame_vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
    } read_vec_t;

    frame_vec_t frame_tab [NUM_LEDS];
    read_vec_t  read_tab  [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_a();
        return {8'h00, red, green, blue};
    endfunction

    function automatic logic [31:0] rgb_b();
        return {8'h00, b_red, b_green, b_blue};
    endfunction

    task automatic write_frame(input logic [23:0] base);
        for (int i = 0; i < NUM_LEDS; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = base + 24'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Waits for the frame start, measures the hold, then plays the driver for
    // n_pulses pixels. A full frame is followed into the next IDLE cycle.
    task automatic run_frame(input string tag, input logic [23:0] base, input int n_pulses,
                             input logic [7:0] commit_mask, input logic exp_pend);
        int n;
        int done0;
        n = 0;
        while (drv_reset !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, " frame start"}, 32'(drv_reset), 32'd1);
        n = 0;
        while (drv_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " hold length"}, 32'(n), 32'(HOLD));
        done0 = done_cnt;
        for (int k = 0; k < n_pulses; k++) begin
            drv_address     = frame_tab[k].addr;
            drv_new_address = frame_tab[k].pulse;
            commit          = commit_mask[k];
            tick();
            check({tag, " pixel"}, rgb_a(), 32'(base + 24'(frame_tab[k].addr)));
            check({tag, " frame_done"}, 32'(frame_done), 32'(frame_tab[k].exp_done));
        end
        drv_new_address = 1'b0;
        commit          = 1'b0;
        if (n_pulses == NUM_LEDS) begin
            check({tag, " pending at done"}, 32'(swap_pending), 32'(exp_pend));
            tick();
            check({tag, " idle after done"}, 32'(busy), 32'd0);
            check({tag, " done pulse width"}, 32'(frame_done), 32'd0);
            check({tag, " done count"}, 32'(done_cnt - done0), 32'd1);
            check({tag, " pending in idle"}, 32'(swap_pending), 32'(exp_pend));
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_snap;

        for (int i = 0; i < NUM_LEDS; i++) begin
            frame_tab[i].addr     = 3'(i);
            frame_tab[i].pulse    = 1'b1;
            frame_tab[i].exp_done = (i == NUM_LEDS - 1);
        end
        read_tab[0] = '{3'd4, 24'h060004, 24'h060004};
        read_tab[1] = '{3'd5, 24'h060005, 24'h000000};
        read_tab[2] = '{3'd0, 24'h060000, 24'h060000};
        read_tab[3] = '{3'd7, 24'h060007, 24'h000000};
        read_tab[4] = '{3'd1, 24'h060001, 24'h060001};
        read_tab[5] = '{3'd6, 24'h060006, 24'h000000};
        read_tab[6] = '{3'd3, 24'h060003, 24'h060003};
        read_tab[7] = '{3'd2, 24'h060002, 24'h060002};

        // Reset state.
        reset = 1'b0;
        repeat (3) tick();
        check("reset drv_reset", 32'(drv_reset), 32'd1);
        check("reset rgb", rgb_a(), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset swap_pending", 32'(swap_pending), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        reset = 1'b1;
        tick();
        check("idle drv_reset low", 32'(drv_reset), 32'd0);

        // Commit in IDLE: swap one cycle later, 16-cycle hold, one full frame.
        write_frame(24'h060000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit pending", 32'(swap_pending), 32'd1);
        check("commit no hold yet", 32'(drv_reset), 32'd0);
        tick();
        check("swap clears pending", 32'(swap_pending), 32'd0);
        check("hold after swap", 32'(drv_reset), 32'd1);
        check("busy in hold", 32'(busy), 32'd1);
        run_frame("f1", 24'h060000, NUM_LEDS, 8'h00, 1'b0);

        // Outputs track drv_address outside RUN; out-of-range reads give 0.
        for (int k = 0; k < 8; k++) begin
            drv_address = read_tab[k].addr;
            tick();
            check("track a", rgb_a(), 32'(read_tab[k].exp_a));
            check("track b range", rgb_b(), 32'(read_tab[k].exp_b));
        end
        drv_address = 3'd6;
        #1;
        check("pixel lag", rgb_a(), 32'h060002);
        tick();
        check("pixel after lag", rgb_a(), 32'h060006);

        // Two commits during RUN merge into one swap after DONE.
        write_frame(24'h0A0000);
        run_frame("f2", 24'h060000, NUM_LEDS, 8'b0000_1010, 1'b1);
        tick();
        check("late swap clears pending", 32'(swap_pending), 32'd0);
        check("late swap hold", 32'(drv_reset), 32'd1);
        run_frame("f3", 24'h0A0000, NUM_LEDS, 8'h00, 1'b0);

        // Periodic refresh with no commits: starts 100 cycles apart, data unchanged.
        run_frame("f4", 24'h0A0000, NUM_LEDS, 8'h00, 1'b0);
        check("refresh period 1", 32'(rise_last - rise_prev), 32'(REFRESH));
        run_frame("f5", 24'h0A0000, NUM_LEDS, 8'h00, 1'b0);
        check("refresh period 2", 32'(rise_last - rise_prev), 32'(REFRESH));

        // Driver stalls after 3 pulses: abort 50 cycles into RUN.
        done_snap = done_cnt;
        run_frame("f6", 24'h0A0000, 3, 8'h00, 1'b0);
        repeat (TMO - 4) tick();
        check("run before timeout", 32'(busy), 32'd1);
        check("no timeout yet", 32'(timeout), 32'd0);
        tick();
        check("abort to idle", 32'(busy), 32'd0);
        check("timeout set", 32'(timeout), 32'd1);
        check("no done on abort", 32'(done_cnt - done_snap), 32'd0);
        run_frame("f7", 24'h0A0000, NUM_LEDS, 8'h00, 1'b0);
        check("timeout sticky", 32'(timeout), 32'd1);

        // Put buffer 1 on display, then reset mid-RUN with a commit pending.
        write_frame(24'h0C0000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_frame("f8", 24'h0C0000, NUM_LEDS, 8'h00, 1'b0);
        run_frame("f9", 24'h0C0000, 2, 8'b0000_0001, 1'b0);
        check("pending before reset", 32'(swap_pending), 32'd1);
        check("busy before reset", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check("mid reset drv_reset", 32'(drv_reset), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset pending", 32'(swap_pending), 32'd0);
        check("mid reset frame_done", 32'(frame_done), 32'd0);
        check("mid reset timeout", 32'(timeout), 32'd0);
        check("mid reset rgb", rgb_a(), 32'd0);
        reset       = 1'b1;
        drv_address = 3'd3;
        tick();
        check("front_sel back to 0", rgb_a(), 32'h0A0003);
        check("post reset drv_reset", 32'(drv_reset), 32'd0);
        check("post reset busy", 32'(busy), 32'd0);

        // Commit after reset behaves like the first one.
        write_frame(24'h0E0000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("re-commit pending", 32'(swap_pending), 32'd1);
        check("re-commit no hold yet", 32'(drv_reset), 32'd0);
        tick();
        check("re-commit swap", 32'(swap_pending), 32'd0);
        check("re-commit hold", 32'(drv_reset), 32'd1);
        run_frame("f10", 24'h0E0000, NUM_LEDS, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
